pipe_stage_reg: RTL

Generic, parametrised inter-stage pipeline register with a valid/ready handshake. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 64-bit RISC-V pipeline. Control and datapath fields are carried as separate packed buses. Beyond plain stall/flush, it adds:
- an optional 2-entry skid buffer, so in_ready is registered;
- bubble insertion that forces the control fields to zero;
- a saturating back-pressure cycle counter for performance debug.

---
 rtl/cpu_pipe_pkg.sv | 58 +++++
 rtl/pipe_slot.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared field layout for the RV64 pipeline registers: control-bit positions,
// per-stage data widths and data-field offsets.
package cpu_pipe_pkg;

  localparam int PIPE_CTRL_W   = 8;
  localparam int REGWRITE_BIT  = 7;
  localparam int MEMTOREG_BIT  = 6;
  localparam int BRANCH_BIT    = 5;
  localparam int MEMREAD_BIT   = 4;
  localparam int MEMWRITE_BIT  = 3;
  localparam int ALUSRC_BIT    = 2;
  localparam int ALUOP_MSB     = 1;
  localparam int ALUOP_LSB     = 0;

  localparam int XLEN          = 64;
  localparam int REG_ADDR_W    = 5;

  // IF/ID: pc, instruction
  localparam int IFID_PC_LSB   = 0;
  localparam int IFID_INSN_LSB = IFID_PC_LSB + XLEN;
  localparam int IFID_DATA_W   = IFID_INSN_LSB + 32;

  // ID/EX: pc, rd1, rd2, imm, funct3/funct7, rs1, rs2, rd
  localparam int IDEX_PC_LSB   = 0;
  localparam int IDEX_RD1_LSB  = IDEX_PC_LSB  + XLEN;
  localparam int IDEX_RD2_LSB  = IDEX_RD1_LSB + XLEN;
  localparam int IDEX_IMM_LSB  = IDEX_RD2_LSB + XLEN;
  localparam int IDEX_FUNCT_LSB = IDEX_IMM_LSB + XLEN;
  localparam int IDEX_RS1_LSB  = IDEX_FUNCT_LSB + 10;
  localparam int IDEX_RS2_LSB  = IDEX_RS1_LSB + REG_ADDR_W;
  localparam int IDEX_RD_LSB   = IDEX_RS2_LSB + REG_ADDR_W;
  localparam int IDEX_DATA_W   = IDEX_RD_LSB  + REG_ADDR_W;

  // EX/MEM: branch target, alu result, store data, zero flag, rd
  localparam int EXMEM_BT_LSB   = 0;
  localparam int EXMEM_ALU_LSB  = EXMEM_BT_LSB  + XLEN;
  localparam int EXMEM_RD2_LSB  = EXMEM_ALU_LSB + XLEN;
  localparam int EXMEM_ZERO_BIT = EXMEM_RD2_LSB + XLEN;
  localparam int EXMEM_RD_LSB   = EXMEM_ZERO_BIT + 1;
  localparam int EXMEM_DATA_W   = EXMEM_RD_LSB + REG_ADDR_W;

  // MEM/WB: load data, alu result, rd
  localparam int MEMWB_MEM_LSB = 0;
  localparam int MEMWB_ALU_LSB = MEMWB_MEM_LSB + XLEN;
  localparam int MEMWB_RD_LSB  = MEMWB_ALU_LSB + XLEN;
  localparam int MEMWB_DATA_W  = MEMWB_RD_LSB + REG_ADDR_W;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data register; ctrl is forced to zero whenever the slot is invalid.
module pipe_slot
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W     = PIPE_CTRL_W,
  parameter int DATA_W     = 256,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ld_ctrl_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ld_ctrl_i;
      data_d  = ld_data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLEAR_DATA != 0) data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid slot,
// flush, bubble zeroing of control and a saturating back-pressure counter.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W     = PIPE_CTRL_W,
  parameter int DATA_W     = 256,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ld_ctrl;
  logic [DATA_W-1:0] m_data, s_data, m_ld_data;
  logic              m_load, m_clear, s_load, s_clear;
  logic              push, pop;
  logic [CNT_W-1:0]  stall_q;

  assign pop  = m_valid && out_ready;
  assign push = in_valid && in_ready;

  // With a skid slot, M refills from S before ever taking new input,
  // which keeps the order FIFO while in_ready comes straight off S.valid.
  always_comb begin
    m_load    = 1'b0;
    m_clear   = 1'b0;
    s_load    = 1'b0;
    s_clear   = 1'b0;
    m_ld_ctrl = in_ctrl;
    m_ld_data = in_data;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (s_valid) begin
      if (pop) begin
        m_load    = 1'b1;
        m_ld_ctrl = s_ctrl;
        m_ld_data = s_data;
        s_clear   = 1'b1;
      end
    end else begin
      if (push && (!m_valid || pop)) m_load = 1'b1;
      else if (push)                 s_load = 1'b1;
      if (pop && !push)              m_clear = 1'b1;
    end
  end

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk       (clk),
    .rst_ni    (rst),
    .load_i    (m_load),
    .clear_i   (m_clear),
    .ld_ctrl_i (m_ld_ctrl),
    .ld_data_i (m_ld_data),
    .valid_o   (m_valid),
    .ctrl_o    (m_ctrl),
    .data_o    (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_skid (
        .clk       (clk),
        .rst_ni    (rst),
        .load_i    (s_load),
        .clear_i   (s_clear),
        .ld_ctrl_i (in_ctrl),
        .ld_data_i (in_data),
        .valid_o   (s_valid),
        .ctrl_o    (s_ctrl),
        .data_o    (s_data)
      );
      assign in_ready = !s_valid;
    end else begin : g_noskid
      assign s_valid  = 1'b0;
      assign s_ctrl   = '0;
      assign s_data   = '0;
      assign in_ready = !m_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (m_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign out_valid = m_valid;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;
  assign stall_cnt = stall_q;

endmodule
